// File: rtl/mult_div_seq.sv
// Iterative signed/unsigned multiply and restoring divide with HI/LO result registers.
// Latency: WIDTH+1 cycles from accepted start to done; 1 cycle for divide-by-zero.
// Backpressure: start is sampled only in IDLE and ignored while busy; the next op may start on the done cycle.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, next_state;
  logic                 op_r;      // 0 = multiply, 1 = divide
  logic                 neg_q;     // product / quotient must be negated
  logic                 neg_r;     // remainder must be negated (dividend sign)
  logic                 dz_r;      // divide-by-zero short path
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc;       // multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic                 last_iter;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift, div_trial;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand magnitudes and one iteration of the shift-add / restoring-divide datapath.
  always_comb begin
    a_abs     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_abs     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    last_iter = (cnt == CW'(WIDTH - 1));
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, b_mag};
    div_ok    = ~div_trial[WIDTH];
    if (op_r) begin
      acc_step = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: divide by zero bypasses CALC.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (op && (b == '0)) ? FIX : CALC;
      CALC:    if (last_iter) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath, result registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_r     <= 1'b0;
      cnt      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy     <= (next_state != IDLE);
      done     <= (state == FIX);
      div_zero <= (state == FIX) && dz_r;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_signed && a[WIDTH-1];
            dz_r  <= op && (b == '0);
            cnt   <= '0;
            a_mag <= a_abs;
            b_mag <= b_abs;
            acc   <= op ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          // A zero divisor leaves HI/LO untouched.
          if (!dz_r) begin
            if (op_r) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Iterative multiply/divide sequencer for the multi-cycle MIPS datapath, parametrised in operand width. The control unit pulses `start` with an operation select, holds its wait state while `busy` is high, and reacts to `done` and `div_zero`. The block replaces the fixed 32-bit mult/div pair. It adds signed/unsigned mode, a divide-by-zero early exit, and HI/LO result registers that hold their value between operations.

## Interface
- `WIDTH`, default 32: operand width. Must be even and ≥ 4. HI and LO are each `WIDTH` bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `is_signed`  in  1  1 = two's-complement operands; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend; sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor; sampled with `start`.
- `hi`  out  WIDTH  registered HI: product upper half, or remainder.
- `lo`  out  WIDTH  registered LO: product lower half, or quotient.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when the operation completes.
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, for divide with `b == 0`.

## Operation
- The FSM has three states: IDLE, CALC and FIX.
- **IDLE, `start` = 1:**
  - Latch `op` and `is_signed`.
  - Latch |a| and |b| (absolute value when signed, raw when unsigned).
  - Record the result sign(s) and clear the iteration counter.
  - Set `busy` and go to CALC.
- **Divide by zero:** if `op` = 1 and `b` == 0, skip CALC and go straight to FIX with a div-zero flag set.
- **CALC, multiply:** shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle.
- **CALC exit:** after exactly WIDTH iterations, go to FIX.
- **FIX, multiply:** negate the 2·WIDTH-bit magnitude if the signs differ. `{hi,lo}` = a·b.
- **FIX, divide:** `lo` = quotient truncated toward zero. `hi` = remainder carrying the sign of the dividend. This is the MIPS DIV/DIVU contract.
- **FIX, all cases:** pulse `done`, clear `busy`, return to IDLE.
- **FIX, div-zero path:** `hi` and `lo` are NOT written; they keep their previous values. `div_zero` = 1 together with `done`.
- **Signed overflow:** MIN / −1 gives `lo` = MIN and `hi` = 0 (wraps). No flag is raised.
- **Register update rule:** `hi` and `lo` change only in FIX or on reset.
- **Start while busy:** `start` in CALC or FIX is ignored; the operand inputs are don't-care.
- **Reset** (any state, including mid-operation), at the next edge:
  - state = IDLE.
  - `hi` = 0, `lo` = 0.
  - `busy` = 0, `done` = 0, `div_zero` = 0.
  - The counter is cleared and no `done` is produced for the aborted operation.
- `reset` has priority over `start` in the same cycle.

## Timing
- Let edge k be the edge at which `start` is sampled in IDLE.
- **Normal operation:**
  - `busy` = 1 after edge k through edge k+WIDTH+1.
  - CALC occupies edges k+1 … k+WIDTH.
  - FIX is executed at edge k+WIDTH+1. After that edge, `hi`/`lo` are valid, `done` = 1 for one cycle, and `busy` = 0.
  - Total latency is WIDTH+1 cycles (33 for WIDTH = 32).
- **Div-zero path:**
  - `busy` = 1 for exactly one cycle after edge k.
  - After edge k+1: `done` = 1, `div_zero` = 1, `busy` = 0.
- **Back-to-back operation:** `start` asserted during the cycle where `done` is high is accepted, because the FSM is already in IDLE. This gives a minimum issue interval of WIDTH+2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
All scenarios use WIDTH = 32.
- **Unsigned multiply:** `op`=0, `is_signed`=0, a=7, b=6 at edge k -> `done` after edge k+33, `hi`=0x00000000, `lo`=0x0000002A, `busy` high for 33 cycles.
- **Signed multiply:** `op`=0, `is_signed`=1, a=−3 (0xFFFFFFFD), b=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- **Signed divide:** `op`=1, `is_signed`=1, a=−7, b=2 -> `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). Then unsigned a=0xFFFFFFF9, b=2 -> `lo`=0x7FFFFFFC, `hi`=1.
- **Divide by zero:** preload `hi`/`lo` via 7×6, then `op`=1, b=0 -> `done`=`div_zero`=1 after edge k+1, `hi`=0, `lo`=0x2A unchanged, `busy` high one cycle only.
- **Overflow and ignored start:** signed 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. During that run, `start` pulsed at k+5 with a=1, b=1 -> ignored, exactly one `done`.
- **Reset mid-operation:** assert `reset` at edge k+10 of a multiply -> after that edge `busy`=`done`=`div_zero`=0 and `hi`=`lo`=0; no `done` in the following 40 cycles. A new `start` then completes normally.
